fifo_rd_packer: RTL

- Read-side consumer of async_fifo, clocked in the FIFO read domain.
- Pops IN_WIDTH-bit entries using the FIFO's empty/rd_en/rd_data interface and packs RATIO of them into one output word.
- Presents packed words on a valid/ready stream.
- Idle timeout and an explicit flush emit partial words, with a keep mask marking the valid lanes.

---
 rtl/fifo_rd_packer.sv | 114 +++++++++++
 1 files changed

// File: rtl/fifo_rd_packer.sv
// Read-domain consumer of async_fifo: pops IN_WIDTH-bit entries and packs RATIO of them
// into one valid/ready output word, emitting partial words on flush or idle timeout.
module fifo_rd_packer #(
    parameter int IN_WIDTH = 8,
    parameter int RATIO    = 4,
    parameter int TIMEOUT  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      fifo_empty,
    output logic                      fifo_rd_en,
    input  logic [IN_WIDTH-1:0]       fifo_rd_data,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [IN_WIDTH*RATIO-1:0] out_data,
    output logic [RATIO-1:0]          out_keep,
    output logic                      idle
);
    localparam int OW = IN_WIDTH * RATIO;
    localparam int CW = $clog2(RATIO + 1);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] FULL = CW'(RATIO);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    logic [CW-1:0]    r_cnt;
    logic             r_inflight;
    logic [TW-1:0]    r_idle_cnt;
    logic             r_flush_pend;
    logic [OW-1:0]    r_acc;
    logic             r_out_valid;
    logic [OW-1:0]    r_out_data;
    logic [RATIO-1:0] r_out_keep;

    logic             w_slot_free;
    logic             w_full_emit;
    logic             w_part_emit;
    logic             w_emit;
    logic             w_flush_req;
    logic             w_timeout;
    logic             w_rd_en;
    logic             w_idle_inc;
    logic [CW-1:0]    w_wr_lane;
    logic [OW-1:0]    w_acc_next;
    logic [RATIO-1:0] w_keep_part;

    assign w_slot_free = !r_out_valid || out_ready;
    assign w_full_emit = (r_cnt == FULL) && w_slot_free;
    assign w_flush_req = flush || r_flush_pend;
    assign w_timeout   = (TIMEOUT != 0) && (r_idle_cnt == TMAX);
    // A partial word waits for any in-flight entry so it is included, never dropped.
    assign w_part_emit = (w_flush_req || w_timeout) && (r_cnt != '0) && (r_cnt != FULL)
                         && !r_inflight && w_slot_free;
    assign w_emit      = w_full_emit || w_part_emit;
    assign w_rd_en     = !fifo_empty && !w_part_emit
                         && (({1'b0, r_cnt} + {{CW{1'b0}}, r_inflight}) < (CW+1)'(RATIO));
    assign w_idle_inc  = (r_cnt != '0) && !r_inflight && fifo_empty;
    assign w_wr_lane   = w_full_emit ? '0 : r_cnt;

    // Accumulator lanes are cleared on every emission, so unused lanes always read as zero.
    generate
        for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
            assign w_acc_next[gi*IN_WIDTH +: IN_WIDTH] =
                (r_inflight && (w_wr_lane == CW'(gi))) ? fifo_rd_data :
                w_emit ? '0 : r_acc[gi*IN_WIDTH +: IN_WIDTH];
            assign w_keep_part[gi] = (CW'(gi) < r_cnt);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_inflight   <= 1'b0;
            r_idle_cnt   <= '0;
            r_flush_pend <= 1'b0;
            r_acc        <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_keep   <= '0;
        end else begin
            r_inflight <= w_rd_en;
            r_acc      <= w_acc_next;

            if (w_emit) begin
                r_cnt <= r_inflight ? CW'(1) : '0;
            end else if (r_inflight) begin
                r_cnt <= r_cnt + CW'(1);
            end

            if (w_rd_en || w_emit) begin
                r_idle_cnt <= '0;
            end else if (w_idle_inc && (r_idle_cnt != TMAX)) begin
                r_idle_cnt <= r_idle_cnt + TW'(1);
            end

            // A flush only sticks when there is, or is about to be, something to emit.
            r_flush_pend <= w_flush_req && !w_emit && ((r_cnt != '0) || r_inflight || w_rd_en);

            if (w_emit) begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_acc;
                r_out_keep  <= w_full_emit ? '1 : w_keep_part;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign fifo_rd_en = w_rd_en;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_keep   = r_out_keep;
    assign idle       = (r_cnt == '0) && !r_inflight && !r_out_valid;
endmodule
